// File: rtl/clint_timer.sv
// Core-local interruptor: msip, mtimecmp and a prescaled free-running mtime
// behind a single-cycle LSU request/response port.
module clint_timer #(
  parameter int unsigned CLK_FREQ   = 1_000_000_000,
  parameter int unsigned MTIME_FREQ = 1_000_000,
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_msip,
  output logic        o_mtip,
  output logic [63:0] o_mtime
);

  localparam int unsigned DIV = (MTIME_FREQ == 0) ? 0 : CLK_FREQ / MTIME_FREQ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

  if (DIV < 1 || DIV * MTIME_FREQ != CLK_FREQ) begin : gBadDiv
    $error("clint_timer: CLK_FREQ must be a non-zero integer multiple of MTIME_FREQ");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          mtip_q;
  logic          ready_q;
  logic          rspValid_q, rspValid_d;
  logic          rspErr_q, rspErr_d;
  logic [31:0]   rspRdata_q, rspRdata_d;

  logic [31:0] reqOff;
  logic        inWindow;
  logic        selMsip, selCmpLo, selCmpHi, selTimeLo, selTimeHi;
  logic        reqErr, accept, wrEn, tick;
  logic [31:0] rdMux;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = newVal[8*b +: 8];
    end
    return r;
  endfunction

  // Decode is relative to BASE_ADDR so a non-64K-aligned base still works.
  always_comb begin
    reqOff    = i_req_addr - BASE_ADDR;
    inWindow  = (i_req_addr >= BASE_ADDR) && (reqOff[31:16] == 16'h0000);
    selMsip   = inWindow && (reqOff[15:0] == OFF_MSIP);
    selCmpLo  = inWindow && (reqOff[15:0] == OFF_CMP_LO);
    selCmpHi  = inWindow && (reqOff[15:0] == OFF_CMP_HI);
    selTimeLo = inWindow && (reqOff[15:0] == OFF_MTIME_LO);
    selTimeHi = inWindow && (reqOff[15:0] == OFF_MTIME_HI);
    reqErr    = (i_req_addr[1:0] != 2'b00) ||
                !(selMsip || selCmpLo || selCmpHi || selTimeLo || selTimeHi);
    accept    = i_req_valid && ready_q;
    wrEn      = accept && i_req_we && !reqErr;

    rdMux = 32'h0;
    if (selMsip)   rdMux = {31'h0, msip_q};
    if (selCmpLo)  rdMux = mtimecmp_q[31:0];
    if (selCmpHi)  rdMux = mtimecmp_q[63:32];
    if (selTimeLo) rdMux = mtime_q[31:0];
    if (selTimeHi) rdMux = mtime_q[63:32];
  end

  // A software write to mtime overrides the tick increment for that cycle.
  always_comb begin
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;

    if (wrEn && selTimeLo)
      mtime_d = {mtime_q[63:32], mergeBytes(mtime_q[31:0], i_req_wdata, i_req_wstrb)};
    if (wrEn && selTimeHi)
      mtime_d = {mergeBytes(mtime_q[63:32], i_req_wdata, i_req_wstrb), mtime_q[31:0]};
    if (wrEn && selCmpLo)
      mtimecmp_d[31:0] = mergeBytes(mtimecmp_q[31:0], i_req_wdata, i_req_wstrb);
    if (wrEn && selCmpHi)
      mtimecmp_d[63:32] = mergeBytes(mtimecmp_q[63:32], i_req_wdata, i_req_wstrb);
    if (wrEn && selMsip && i_req_wstrb[0])
      msip_d = i_req_wdata[0];

    rspValid_d = accept;
    rspErr_d   = accept && reqErr;
    rspRdata_d = (accept && !i_req_we && !reqErr) ? rdMux : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      ready_q    <= 1'b0;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspRdata_q <= 32'h0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
      ready_q    <= 1'b1;
      rspValid_q <= rspValid_d;
      rspErr_q   <= rspErr_d;
      rspRdata_q <= rspRdata_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_rsp_valid = rspValid_q;
  assign o_rsp_err   = rspErr_q;
  assign o_rsp_rdata = rspRdata_q;
  assign o_msip      = msip_q;
  assign o_mtip      = mtip_q;
  assign o_mtime     = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer at DIV=4: directed vector table, multi-cycle
// corner sequences and random traffic, all compared against a register-level model.
module tb_clint_timer;

  localparam int unsigned CLKF = 1_000_000_000;
  localparam int unsigned MTF  = 250_000_000;
  localparam int          DIV  = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWe = 1'b0;
  logic [31:0] reqAddr = 32'h0;
  logic [31:0] reqWdata = 32'h0;
  logic [3:0]  reqWstrb = 4'h0;
  logic        reqReady, rspValid, rspErr, msip, mtip;
  logic [31:0] rspRdata;
  logic [63:0] mtime;

  int checks = 0;
  int failures = 0;

  // Reference model state: architectural registers plus elapsed cycles since reset.
  logic [63:0] mTime, mCmp;
  logic        mMsip, mMtip, mReady;
  logic        mRspValid, mRspErr;
  logic [31:0] mRspRdata;
  int          mEdges;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  clint_timer #(.CLK_FREQ(CLKF), .MTIME_FREQ(MTF), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(reqValid), .i_req_we(reqWe), .i_req_addr(reqAddr),
    .i_req_wdata(reqWdata), .i_req_wstrb(reqWstrb),
    .o_req_ready(reqReady), .o_rsp_valid(rspValid), .o_rsp_rdata(rspRdata),
    .o_rsp_err(rspErr), .o_msip(msip), .o_mtip(mtip), .o_mtime(mtime)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] mergeWord(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0] strb);
    logic [31:0] r;
    r = oldVal;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = newVal[8*b +: 8];
    return r;
  endfunction

  // Drive one cycle of request, advance the model by one clock, compare after the edge.
  task automatic applyStimulus(input logic v, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
    logic        acc, bad, tickNow, inWin;
    logic [31:0] off, rv;
    logic [63:0] nextTime;
    reqValid = v; reqWe = we; reqAddr = addr; reqWdata = wdata; reqWstrb = strb;

    acc   = v && mReady;
    off   = addr - BASE;
    inWin = (addr >= BASE) && (off <= 32'hFFFF) && (addr[1:0] == 2'b00);
    bad   = 1'b1;
    rv    = 32'h0;
    if (inWin) begin
      case (off)
        32'h0000: begin bad = 1'b0; rv = {31'h0, mMsip}; end
        32'h4000: begin bad = 1'b0; rv = mCmp[31:0];     end
        32'h4004: begin bad = 1'b0; rv = mCmp[63:32];    end
        32'hBFF8: begin bad = 1'b0; rv = mTime[31:0];    end
        32'hBFFC: begin bad = 1'b0; rv = mTime[63:32];   end
        default:  bad = 1'b1;
      endcase
    end

    tickNow   = (mEdges % DIV) == DIV - 1;
    mRspValid = acc;
    mRspErr   = acc && bad;
    mRspRdata = (acc && !we && !bad) ? rv : 32'h0;
    mMtip     = (mTime >= mCmp);
    nextTime  = tickNow ? mTime + 64'd1 : mTime;
    if (acc && we && !bad) begin
      case (off)
        32'h0000: if (strb[0]) mMsip = wdata[0];
        32'h4000: mCmp[31:0]  = mergeWord(mCmp[31:0], wdata, strb);
        32'h4004: mCmp[63:32] = mergeWord(mCmp[63:32], wdata, strb);
        32'hBFF8: nextTime = {mTime[63:32], mergeWord(mTime[31:0], wdata, strb)};
        32'hBFFC: nextTime = {mergeWord(mTime[63:32], wdata, strb), mTime[31:0]};
        default: ;
      endcase
    end
    mTime  = nextTime;
    mReady = 1'b1;
    mEdges++;

    @(posedge clk);
    #1;
    checkOutput("rspValid", 64'(rspValid), 64'(mRspValid));
    checkOutput("rspErr",   64'(rspErr),   64'(mRspErr));
    checkOutput("rspRdata", 64'(rspRdata), 64'(mRspRdata));
    checkOutput("mtime",    mtime,         mTime);
    checkOutput("msip",     64'(msip),     64'(mMsip));
    checkOutput("mtip",     64'(mtip),     64'(mMtip));
    checkOutput("reqReady", 64'(reqReady), 64'(mReady));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    reqValid = 1'b0; reqWe = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0; reqWstrb = 4'h0;
    #1;
    checkOutput("rstRspValid", 64'(rspValid), 64'h0);
    checkOutput("rstRspRdata", 64'(rspRdata), 64'h0);
    checkOutput("rstRspErr",   64'(rspErr),   64'h0);
    checkOutput("rstMtip",     64'(mtip),     64'h0);
    checkOutput("rstMsip",     64'(msip),     64'h0);
    checkOutput("rstReady",    64'(reqReady), 64'h0);
    checkOutput("rstMtime",    mtime,         64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mTime = 64'h0; mCmp = '1; mMsip = 1'b0; mMtip = 1'b0; mReady = 1'b0;
    mRspValid = 1'b0; mRspErr = 1'b0; mRspRdata = 32'h0; mEdges = 0;
  endtask

  initial begin
    int fiveAt, riseAt;
    logic reached;
    logic [31:0] addrs [10];

    // Directed vectors: {we, addr, wdata, wstrb, expected rdata, expected err}.
    vecs.push_back('{1'b0, BASE + 32'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{1'b0, BASE + 32'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{1'b0, BASE + 32'hBFF8, 32'h0, 4'h0, 32'h0,         1'b0});
    vecs.push_back('{1'b0, BASE + 32'h0000, 32'h0, 4'h0, 32'h0,         1'b0});
    vecs.push_back('{1'b1, BASE + 32'h0000, 32'hFFFF_FFFF, 4'b0001, 32'h0, 1'b0});
    vecs.push_back('{1'b0, BASE + 32'h0000, 32'h0, 4'h0, 32'h1,         1'b0});
    vecs.push_back('{1'b1, BASE + 32'h0000, 32'h0, 4'b0000, 32'h0,      1'b0});
    vecs.push_back('{1'b0, BASE + 32'h0000, 32'h0, 4'h0, 32'h1,         1'b0});
    vecs.push_back('{1'b0, BASE + 32'h0010, 32'h0, 4'h0, 32'h0,         1'b1});
    vecs.push_back('{1'b1, BASE + 32'h4002, 32'h1234_5678, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, BASE + 32'h1_0000, 32'h0, 4'h0, 32'h0,       1'b1});
    vecs.push_back('{1'b0, BASE - 32'h4, 32'h0, 4'h0, 32'h0,            1'b1});
    vecs.push_back('{1'b0, BASE + 32'h0003, 32'h0, 4'h0, 32'h0,         1'b1});
    vecs.push_back('{1'b0, BASE + 32'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0});

    #2;
    applyReset();
    idle(1);
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      checkOutput($sformatf("vec%0d_rdata", i), 64'(rspRdata), 64'(vecs[i].expRdata));
      checkOutput($sformatf("vec%0d_err", i),   64'(rspErr),   64'(vecs[i].expErr));
    end
    checkOutput("msipAfterTable", 64'(msip), 64'h1);

    // Prescaler: 40 cycles after reset release gives exactly 10 ticks.
    applyReset();
    idle(40);
    checkOutput("mtimeAfter40", mtime, 64'd10);

    // Carry from the low into the high word.
    applyStimulus(1'b1, 1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFE, 4'hF);
    applyStimulus(1'b1, 1'b1, BASE + 32'hBFFC, 32'h0, 4'hF);
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      idle(1);
      if (mtime[63:32] != 32'h0) reached = 1'b1;
    end
    checkOutput("carryReached", 64'(reached), 64'h1);
    checkOutput("carryValue", mtime, 64'h0000_0001_0000_0000);
    applyStimulus(1'b1, 1'b0, BASE + 32'hBFFC, 32'h0, 4'h0);
    checkOutput("readMtimeHi", 64'(rspRdata), 64'h1);

    // Write into mtime during a tick cycle: the write wins, no increment.
    applyStimulus(1'b1, 1'b1, BASE + 32'hBFFC, 32'h0, 4'hF);
    while ((mEdges % DIV) != DIV - 1) idle(1);
    applyStimulus(1'b1, 1'b1, BASE + 32'hBFF8, 32'h100, 4'hF);
    checkOutput("tickWriteWins", mtime, 64'h100);

    // Full 64-bit wrap from all ones.
    applyStimulus(1'b1, 1'b1, BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b1, 1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      idle(1);
      if (mtime == 64'h0) reached = 1'b1;
    end
    checkOutput("allOnesWrap", 64'(reached), 64'h1);

    // Timer interrupt: rises one cycle after mtime reaches mtimecmp, falls after raise.
    applyReset();
    idle(1);
    applyStimulus(1'b1, 1'b1, BASE + 32'h4004, 32'h0, 4'hF);
    applyStimulus(1'b1, 1'b1, BASE + 32'h4000, 32'h5, 4'hF);
    fiveAt = -1; riseAt = -1;
    for (int i = 0; i < 60 && riseAt < 0; i++) begin
      idle(1);
      if (fiveAt < 0 && mtime == 64'd5) fiveAt = i;
      if (mtip) riseAt = i;
    end
    checkOutput("mtipRiseLag", 64'(riseAt - fiveAt), 64'd1);
    applyStimulus(1'b1, 1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
    checkOutput("mtipHoldAfterWrite", 64'(mtip), 64'h1);
    idle(1);
    checkOutput("mtipFall", 64'(mtip), 64'h0);

    // Reset with a response pending: it must not appear.
    applyStimulus(1'b1, 1'b0, BASE + 32'h4000, 32'h0, 4'h0);
    applyReset();
    idle(2);

    // Random traffic against the model.
    addrs = '{BASE, BASE + 32'h4000, BASE + 32'h4004, BASE + 32'hBFF8, BASE + 32'hBFFC,
              BASE + 32'h0010, BASE + 32'h4002, BASE + 32'h1_0000, BASE - 32'h4,
              BASE + 32'h8000};
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, 1'($urandom % 2), addrs[$urandom % 10],
                    ($urandom % 2) ? $urandom : $urandom_range(0, 64),
                    4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor (CLINT) peripheral in the CLINT window (0x0200_0000–0x0200_FFFF), directly downstream of the LSU memory-source decode (LSU_MEM_SRC_CLINT).
- Holds msip, 64-bit mtimecmp and 64-bit free-running mtime; serves LSU word accesses.
- Drives machine software/timer interrupt-pending lines to the CSR/trap logic and exports mtime for time/timeh CSR reads.

Parameters:
- CLK_FREQ, 1_000_000_000, core clock in Hz (package value).
- MTIME_FREQ, 1_000_000, mtime tick rate in Hz; DIV = CLK_FREQ/MTIME_FREQ, must be an integer ≥1 (elaboration error otherwise).
- BASE_ADDR, 32'h0200_0000, window base; register offsets are relative to it.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  access request from LSU
- i_req_we  in  1  1=write, 0=read
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  write data
- i_req_wstrb  in  4  byte-lane enables for writes
- o_req_ready  out  1  request accepted this cycle
- o_rsp_valid  out  1  response valid (reads and writes)
- o_rsp_rdata  out  32  read data
- o_rsp_err  out  1  access fault (unmapped/misaligned)
- o_msip  out  1  machine software interrupt pending
- o_mtip  out  1  machine timer interrupt pending
- o_mtime  out  64  current mtime

Behaviour:
- Reset (async assert, sync release): msip=0, mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_mtip=0, o_req_ready=0.
- o_req_ready=1 every cycle out of reset; one request per cycle; request accepted when i_req_valid&&o_req_ready.
- Register map (offset):
  - 0x0000 msip: bit0 R/W, bits 31:1 read 0.
  - 0x4000 mtimecmp[31:0]
  - 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0]
  - 0xBFFC mtime[63:32]
- Response latency exactly 1 cycle: the cycle after acceptance, o_rsp_valid=1 for one cycle with registered rdata/err. Write responses carry rdata=0.
- Reads return register value as it was in the acceptance cycle (before that cycle's tick or write).
- Writes: each byte lane updated only where wstrb bit set; msip uses lane 0 bit0 only.
- Faults (err=1, rdata=0, no state change):
  - addr[1:0]≠0;
  - offset not in map;
  - address outside BASE_ADDR..BASE_ADDR+0xFFFF.
- Prescaler: counts 0..DIV-1 every cycle; tick when count==DIV-1, then wraps to 0. DIV=1 means tick every cycle.
- mtime:
  - On tick, mtime += 1 as a full 64-bit add, so 0x0000_0000_FFFF_FFFF → 0x0000_0001_0000_0000 and all-ones → 0.
  - A write to either mtime half in a tick cycle wins: written lanes take wdata, the other half holds, and the increment is dropped. Prescaler unaffected.
- o_mtip: registered each cycle from (mtime ≥ mtimecmp, unsigned 64-bit) using current register values; lags register state by 1 cycle.
  - Clears 1 cycle after mtimecmp is raised above mtime; level-sensitive, no latch.
- o_msip = msip register (combinational from flop).
- o_mtime = mtime register.
- Reset mid-transaction: pending response discarded; o_rsp_valid=0 through and after reset until a new request.

Test Plan:
- Reset, then read 0x0200_4000/0x0200_4004/0x0200_BFF8/0x0200_0000 → 0xFFFF_FFFF, 0xFFFF_FFFF, 0, 0; each o_rsp_valid one cycle after request, err=0; o_mtip=0.
- CLK_FREQ=1e9, MTIME_FREQ=250e6 (DIV=4): hold 40 cycles after reset → o_mtime=10; mtime increments exactly every 4th cycle.
- Write mtime lo=0xFFFF_FFFE, hi=0 → after 2 ticks o_mtime=64'h0000_0001_0000_0000; read 0xBFFC → 0x0000_0001.
- Write mtimecmp hi=0, lo=5 with mtime counting from 0 → o_mtip rises one cycle after mtime reaches 5; write mtimecmp lo=0xFFFF_FFFF → o_mtip falls 1 cycle after the write takes effect.
- Write 0x0200_0000 data 0xFFFF_FFFF wstrb=4'b0001 → o_msip=1, read returns 0x1; write with wstrb=4'b0000 → msip unchanged.
- Read 0x0200_0010 and write 0x0200_4002 → o_rsp_err=1, rdata=0, all registers unchanged. Write mtime lo=0x100 in a tick cycle → mtime=0x100, not 0x101.
